// File: rtl/game_of_life_pkg.sv
// Shared types and constants for the life-grid display path.
package game_of_life_pkg;

    localparam int GRID_DIM   = 8;
    localparam int GRID_CELLS = GRID_DIM * GRID_DIM;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        BLANK
    } scan_state_t;

    typedef logic [$clog2(GRID_DIM)-1:0] row_idx_t;

    // One-hot row drive pattern, active-high.
    function automatic logic [GRID_DIM-1:0] row_onehot(input row_idx_t r);
        return GRID_DIM'(1) << r;
    endfunction

endpackage

// File: rtl/grid_scan_driver_if.sv
// Grid bus between DATAPATH (master) and the scan driver (slave).
interface grid_scan_driver_if;
    import game_of_life_pkg::*;

    logic [GRID_CELLS-1:0] grid;
    logic                  grid_valid;

    modport master (output grid, output grid_valid);
    modport slave  (input  grid, input  grid_valid);

endinterface

// File: rtl/grid_scan_driver_scan_timer.sv
// Loadable down-counter: holds at zero, done while running at zero.
module scan_timer #(
    parameter int W = 4
) (
    input  logic         clka,
    input  logic         stop_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         run,
    output logic [W-1:0] count,
    output logic         done
);

    logic [W-1:0] cnt;

    // Load takes priority; otherwise count down while running, stop at zero.
    always_ff @(posedge clka or negedge stop_n) begin
        if (!stop_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign count = cnt;
    assign done  = run && (cnt == '0);

endmodule

// File: rtl/grid_scan_driver.sv
// Row-multiplexed LED scan of the 8x8 life grid with tear-free frame swap.
module grid_scan_driver
    import game_of_life_pkg::*;
#(
    parameter int ON_CYC      = 1000,
    parameter int BLANK_CYC   = 16,
    parameter bit ROW_ACT_LOW = 1'b0,
    parameter bit COL_ACT_LOW = 1'b0
) (
    input  logic                  clka,
    input  logic                  stop_n,
    grid_scan_driver_if.slave     bus,
    input  logic                  en,
    output logic [GRID_DIM-1:0]   row_sel,
    output logic [GRID_DIM-1:0]   col_data,
    output logic                  frame_done,
    output logic                  overrun
);

    localparam int TMAX = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] ON_LD = TW'(ON_CYC - 1);
    localparam logic [TW-1:0] BL_LD = TW'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
    localparam row_idx_t LAST_ROW   = row_idx_t'(GRID_DIM - 1);
    localparam logic [GRID_DIM-1:0] ROW_OFF = {GRID_DIM{ROW_ACT_LOW}};
    localparam logic [GRID_DIM-1:0] COL_OFF = {GRID_DIM{COL_ACT_LOW}};

    scan_state_t           state, nxt_state;
    row_idx_t              row, nxt_row;
    logic [GRID_CELLS-1:0] stage, frame, nxt_frame;
    logic                  pending, loaded;

    logic          t_load, t_run, t_done;
    logic [TW-1:0] t_val, t_cnt, nxt_cnt;
    logic          take, nxt_fd;
    logic [GRID_DIM-1:0] disp_row, disp_col;

    assign t_run = (state != IDLE);

    scan_timer #(.W(TW)) u_timer (
        .clka     (clka),
        .stop_n   (stop_n),
        .load     (t_load),
        .load_val (t_val),
        .run      (t_run),
        .count    (t_cnt),
        .done     (t_done)
    );

    // Next-state decode. Outputs are registered from the next state, so
    // frame_done is predicted one cycle ahead from the timer's next count.
    always_comb begin
        nxt_state = state;
        nxt_row   = row;
        t_load    = 1'b0;
        t_val     = '0;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (en && (pending || bus.grid_valid || loaded)) begin
                    nxt_state = SHOW;
                    nxt_row   = '0;
                    t_load    = 1'b1;
                    t_val     = ON_LD;
                    take      = pending || bus.grid_valid;
                end
            end
            SHOW: begin
                if (t_done) begin
                    t_load = 1'b1;
                    if (BLANK_CYC > 0) begin
                        nxt_state = BLANK;
                        t_val     = BL_LD;
                    end else begin
                        nxt_row = row + 1'b1;
                        t_val   = ON_LD;
                        take    = (row == LAST_ROW) && (pending || bus.grid_valid);
                    end
                end
            end
            BLANK: begin
                if (t_done) begin
                    nxt_state = SHOW;
                    nxt_row   = row + 1'b1;
                    t_load    = 1'b1;
                    t_val     = ON_LD;
                    take      = (row == LAST_ROW) && (pending || bus.grid_valid);
                end
            end
            default: nxt_state = IDLE;
        endcase
        if (!en) begin
            nxt_state = IDLE;
            nxt_row   = '0;
            t_load    = 1'b1;
            t_val     = '0;
            take      = 1'b0;
        end

        nxt_frame = take ? (bus.grid_valid ? bus.grid : stage) : frame;
        nxt_cnt   = t_load ? t_val : ((t_run && (t_cnt != '0)) ? t_cnt - 1'b1 : t_cnt);
        nxt_fd    = (nxt_cnt == '0) && (nxt_row == LAST_ROW) &&
                    ((nxt_state == BLANK) || ((nxt_state == SHOW) && (BLANK_CYC == 0)));
        disp_row  = (nxt_state == SHOW) ? row_onehot(nxt_row) : '0;
        disp_col  = (nxt_state == SHOW) ? nxt_frame[{nxt_row, 3'b000} +: GRID_DIM] : '0;
    end

    // Scan FSM, frame buffer and polarity-adjusted output registers.
    always_ff @(posedge clka or negedge stop_n) begin
        if (!stop_n) begin
            state      <= IDLE;
            row        <= '0;
            frame      <= '0;
            loaded     <= 1'b0;
            row_sel    <= ROW_OFF;
            col_data   <= COL_OFF;
            frame_done <= 1'b0;
        end else begin
            state      <= nxt_state;
            row        <= nxt_row;
            frame      <= nxt_frame;
            if (take) begin
                loaded <= 1'b1;
            end
            row_sel    <= disp_row ^ ROW_OFF;
            col_data   <= disp_col ^ COL_OFF;
            frame_done <= nxt_fd;
        end
    end

    // Staging register: latest generation wins; overwriting an unconsumed one is sticky overrun.
    always_ff @(posedge clka or negedge stop_n) begin
        if (!stop_n) begin
            stage   <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (bus.grid_valid) begin
                stage <= bus.grid;
            end
            if (take) begin
                pending <= 1'b0;
            end else if (bus.grid_valid) begin
                pending <= 1'b1;
            end
            if (bus.grid_valid && pending && !take) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_grid_scan_driver.sv
// Bench for grid_scan_driver: directed scenarios plus random traffic vs. a positional model.
module tb_grid_scan_driver;
    import game_of_life_pkg::*;

    localparam int ON = 4;
    localparam int BL = 2;
    localparam int RP = ON + BL;
    localparam int FP = 8 * RP;

    logic       clka = 1'b0;
    logic       stop_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] row_sel, col_data;
    logic       frame_done, overrun;

    grid_scan_driver_if bus ();

    grid_scan_driver #(
        .ON_CYC      (ON),
        .BLANK_CYC   (BL),
        .ROW_ACT_LOW (1'b0),
        .COL_ACT_LOW (1'b0)
    ) dut (
        .clka       (clka),
        .stop_n     (stop_n),
        .bus        (bus.slave),
        .en         (en),
        .row_sel    (row_sel),
        .col_data   (col_data),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clka = ~clka;

    int total = 0;
    int bad   = 0;

    // Model: scanning is a pure function of cycles elapsed since the scan started.
    int          cyc = 0;
    int          m_start = 0;
    bit          m_act = 0, m_pend = 0, m_ovr = 0, m_loaded = 0;
    logic [63:0] m_frame = '0, m_stage = '0;

    task automatic model_reset();
        m_act = 0; m_pend = 0; m_ovr = 0; m_loaded = 0;
        m_frame = '0; m_stage = '0;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [7:0] e_rs, e_col;
        bit e_fd;
        int p, r;
        e_rs = '0; e_col = '0; e_fd = 0;
        if (m_act) begin
            p = (cyc - m_start) % FP;
            r = p / RP;
            if ((p % RP) < ON) begin
                e_rs  = 8'(1 << r);
                e_col = m_frame[8*r +: 8];
            end
            e_fd = (p == FP - 1);
        end
        check("row_sel", row_sel, e_rs);
        check("col_data", col_data, e_col);
        check("frame_done", {7'b0, frame_done}, {7'b0, e_fd});
        check("overrun", {7'b0, overrun}, {7'b0, m_ovr});
    endtask

    // One clock: update the model from the inputs seen at this edge, then compare.
    task automatic step();
        bit gv, cons;
        logic [63:0] g;
        @(posedge clka);
        gv = bus.grid_valid;
        g  = bus.grid;
        cons = 0;
        if (!m_act) begin
            if (en && (m_pend || gv || m_loaded)) begin
                if (m_pend || gv) begin
                    m_frame  = gv ? g : m_stage;
                    cons     = 1;
                    m_loaded = 1;
                end
                m_act   = 1;
                m_start = cyc + 1;
            end
        end else if (!en) begin
            m_act = 0;
        end else if (((cyc - m_start) % FP == FP - 1) && (m_pend || gv)) begin
            m_frame = gv ? g : m_stage;
            cons    = 1;
        end
        if (gv) begin
            if (m_pend && !cons) m_ovr = 1;
            m_stage = g;
        end
        if (cons) m_pend = 0;
        else if (gv) m_pend = 1;
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse(input logic [63:0] g);
        bus.grid = g;
        bus.grid_valid = 1'b1;
        step();
        bus.grid_valid = 1'b0;
    endtask

    // Advance until the current cycle's frame position lies in [lo,hi]; bounded.
    task automatic run_to(input int lo, input int hi);
        bit hit;
        int p;
        hit = 0;
        for (int i = 0; i < 4 * FP; i++) begin
            p = (cyc - m_start) % FP;
            if (m_act && p >= lo && p <= hi) begin
                hit = 1;
                break;
            end
            step();
        end
        total++;
        assert (hit) else begin
            bad++;
            $error("FAIL run_to observed=not_reached expected=pos_%0d_to_%0d", lo, hi);
        end
    endtask

    task automatic async_reset_check();
        #2 stop_n = 1'b0;
        #1;
        check("rst_row_sel", row_sel, 8'h00);
        check("rst_col_data", col_data, 8'h00);
        check("rst_frame_done", {7'b0, frame_done}, 8'h00);
        check("rst_overrun", {7'b0, overrun}, 8'h00);
        @(negedge clka);
        stop_n = 1'b1;
        model_reset();
    endtask

    initial begin
        bus.grid = '0;
        bus.grid_valid = 1'b0;
        #12;
        check("init_row_sel", row_sel, 8'h00);
        check("init_col_data", col_data, 8'h00);
        check("init_frame_done", {7'b0, frame_done}, 8'h00);
        check("init_overrun", {7'b0, overrun}, 8'h00);
        @(negedge clka);
        stop_n = 1'b1;

        // Enabled but nothing loaded yet: stays dark.
        en = 1'b1;
        run(3);

        // First frame: corner pixels.
        pulse(64'h8000_0000_0000_0001);
        run(2 * FP);

        // Anti-tear: new grid while row 3 is shown.
        run_to(3 * RP, 3 * RP + ON - 1);
        pulse({$urandom, $urandom});
        run(FP + 10);

        // Coincident strobe on the boundary cycle.
        run_to(FP - 1, FP - 1);
        pulse({$urandom, $urandom});
        run(FP);

        // en drop during row 5, then resume.
        run_to(5 * RP, 5 * RP + 1);
        en = 1'b0;
        run(10);
        en = 1'b1;
        run(FP + 8);

        // Overrun: two strobes inside one frame.
        run_to(RP, RP);
        pulse(64'h0123_4567_89AB_CDEF);
        run(2 * RP);
        pulse(64'hFEDC_BA98_7654_3210);
        run(2 * FP);

        // Async reset in the middle of a SHOW period.
        run_to(2 * RP + 1, 2 * RP + 1);
        async_reset_check();
        run(5);

        // Random traffic.
        en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 79) == 0) en = ~en;
            if ($urandom_range(0, 24) == 0) begin
                bus.grid = {$urandom, $urandom};
                bus.grid_valid = 1'b1;
            end
            step();
            bus.grid_valid = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
